// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic feed scheduler.
package systolic_pkg;

  localparam int SYS_DATA_W = 16;
  localparam int SYS_N      = 4;
  localparam int SYS_MAX_K  = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } sched_state_e;

  // Zero slices needed to push the last real slice through skew and grid.
  function automatic int drain_cycles(input int n);
    return 2 * (n - 1);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Shift-on-enable delay line: output is the input from DEPTH enables earlier, always registered.
// One register of latency per enable plus DEPTH stages; holds its contents while en_i is low.
module skew_delay_line #(
  parameter int DEPTH = 0,
  parameter int W     = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  if (DEPTH == 0) begin : g_direct
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q_q <= '0;
      end else if (en_i) begin
        q_q <= d_i;
      end
    end
  end else begin : g_chain
    logic [W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s < DEPTH; s++) sr_q[s] <= '0;
        q_q <= '0;
      end else if (en_i) begin
        sr_q[0] <= d_i;
        for (int s = 1; s < DEPTH; s++) sr_q[s] <= sr_q[s-1];
        q_q <= sr_q[DEPTH-1];
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/systolic_feed_scheduler.sv
// Sequences one output-stationary NxN job: clear, feed k-slices with diagonal skew, drain, flush, done.
// Bubbles on in_valid freeze the skew lines and array_en; SCHED_PERF_CNT_EN adds stall_cycles_o.
module systolic_feed_scheduler
  import systolic_pkg::*;
#(
  parameter int DATA_W = SYS_DATA_W,
  parameter int N      = SYS_N,
  parameter int MAX_K  = SYS_MAX_K
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [$clog2(MAX_K+1)-1:0]   k_len_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [N*DATA_W-1:0]          in_a_i,
  input  logic [N*DATA_W-1:0]          in_b_i,
  output logic [N*DATA_W-1:0]          north_o,
  output logic [N*DATA_W-1:0]          west_o,
  output logic                         array_en_o,
  output logic                         array_clr_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         result_valid_o
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [15:0]                  stall_cycles_o
`endif
);

  localparam int KW           = $clog2(MAX_K + 1);
  localparam int DRAIN_CYCLES = drain_cycles(N);
  localparam int DCW          = $clog2(DRAIN_CYCLES + 1);

  sched_state_e state_q, state_d;
  logic [KW-1:0]  k_len_q, k_len_d;
  logic [KW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           result_valid_q, result_valid_d;
  logic           array_en_q;

  logic                accept;
  logic                push;
  logic [N*DATA_W-1:0] push_a;
  logic [N*DATA_W-1:0] push_b;

  assign accept = (state_q == S_FEED) && in_valid_i;
  assign push   = accept || (state_q == S_DRAIN);
  // Drain pushes zero slices, so gating the data by accept covers both cases.
  assign push_a = accept ? in_a_i : '0;
  assign push_b = accept ? in_b_i : '0;

  always_comb begin
    state_d        = state_q;
    k_len_d        = k_len_q;
    beat_cnt_d     = beat_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    result_valid_d = result_valid_q;
    in_ready_o     = 1'b0;
    array_clr_o    = 1'b0;
    done_o         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_len_d        = (k_len_i > KW'(MAX_K)) ? KW'(MAX_K) : k_len_i;
          beat_cnt_d     = '0;
          drain_cnt_d    = '0;
          result_valid_d = 1'b0;
          state_d        = S_CLEAR;
        end
      end
      S_CLEAR: begin
        array_clr_o = 1'b1;
        state_d     = (k_len_q == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          beat_cnt_d = beat_cnt_q + KW'(1);
          if (beat_cnt_q + KW'(1) == k_len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
          drain_cnt_d = '0;
          state_d     = S_FLUSH;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      S_FLUSH: begin
        result_valid_d = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      k_len_q        <= '0;
      beat_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      result_valid_q <= 1'b0;
      array_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_len_q        <= k_len_d;
      beat_cnt_q     <= beat_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      result_valid_q <= result_valid_d;
      array_en_q     <= push;
    end
  end

  assign array_en_o     = array_en_q;
  assign busy_o         = (state_q != S_IDLE);
  assign result_valid_o = result_valid_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(.DEPTH(i), .W(DATA_W)) u_north (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (push),
      .d_i    (push_a[i*DATA_W +: DATA_W]),
      .q_o    (north_o[i*DATA_W +: DATA_W])
    );
    skew_delay_line #(.DEPTH(i), .W(DATA_W)) u_west (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (push),
      .d_i    (push_b[i*DATA_W +: DATA_W]),
      .q_o    (west_o[i*DATA_W +: DATA_W])
    );
  end

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      stall_q <= '0;
    end else if ((state_q == S_FEED) && !in_valid_i && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule
